// File: rtl/ps2_scan_decoder_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder slice.
package ps2_pkg;

    localparam logic [7:0] PS2_CODE_EXT = 8'hE0;
    localparam logic [7:0] PS2_CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } ps2State_t;

    typedef struct packed {
        logic [7:0] code;
        logic       extended;
        logic       released;
    } keyEvent_t;

    // Start bit low, stop bit high, odd parity across data and parity bit.
    function automatic logic frameGood(input logic [7:0] code, input logic par,
                                       input logic [1:0] initBits);
        return !initBits[1] && initBits[0] && (^{code, par});
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Valid/ready key-event channel towards the I2C parallelisation logic.
interface ps2_scan_decoder_if;

    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;

    modport master (
        output key_valid,
        output key_code,
        output key_extended,
        output key_release,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_extended,
        input  key_release,
        output key_ready
    );

endinterface

// File: rtl/ps2_scan_decoder_fifo.sv
// Small synchronous key-event FIFO; head data reads as zero while empty.
module key_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  keyEvent_t wrData,
    output keyEvent_t rdData,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    keyEvent_t   mem [DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    logic        doPush;
    logic        doPop;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign doPush = push && (!full || pop);
    assign doPop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
    end

    assign rdData = empty ? '0 : mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/ps2_scan_decoder.sv
// Validates PS/2 frames, folds E0/F0 prefixes into key events and queues them.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_ready,
    input  logic [7:0]             scan_code,
    input  logic                   parity_bit,
    input  logic [1:0]             comm_init_bits,
    output logic                   frame_ack,
    ps2_scan_decoder_if.master     keyBus,
    output logic                   frame_err,
    output logic                   fifo_overflow,
    output logic [ERR_CNT_W-1:0]   err_count
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    ps2State_t       state;
    ps2State_t       nextState;
    logic            frameReadyQ;
    logic [TO_W-1:0] timeoutCnt;
    logic            accept;
    logic            good;
    logic            expired;
    logic            pushReq;
    keyEvent_t       pushEvt;
    keyEvent_t       headEvt;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            popFire;
    logic            dropEvt;
    logic            badFrame;

    assign accept   = frame_ready && !frameReadyQ;
    assign good     = frameGood(scan_code, parity_bit, comm_init_bits);
    assign badFrame = accept && !good;
    // An accept landing on the expiry cycle takes priority over the timeout.
    assign expired  = (state != IDLE) && !accept &&
                      (timeoutCnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign popFire  = !fifoEmpty && keyBus.key_ready;
    assign dropEvt  = pushReq && fifoFull && !popFire;

    always_comb begin
        nextState = state;
        pushReq   = 1'b0;
        pushEvt   = '{code: scan_code,
                      extended: (state == EXT) || (state == EXT_BRK),
                      released: (state == BRK) || (state == EXT_BRK)};
        if (accept && good) begin
            if (scan_code == PS2_CODE_EXT) begin
                if (state == IDLE)     nextState = EXT;
                else if (state == BRK) nextState = EXT_BRK;
            end else if (scan_code == PS2_CODE_BRK) begin
                if (state == IDLE)     nextState = BRK;
                else if (state == EXT) nextState = EXT_BRK;
            end else begin
                pushReq   = 1'b1;
                nextState = IDLE;
            end
        end else if (badFrame || expired) begin
            nextState = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            frameReadyQ   <= 1'b0;
            timeoutCnt    <= '0;
            frame_ack     <= 1'b0;
            frame_err     <= 1'b0;
            fifo_overflow <= 1'b0;
            err_count     <= '0;
        end else begin
            state         <= nextState;
            frameReadyQ   <= frame_ready;
            frame_ack     <= accept;
            frame_err     <= badFrame || expired;
            fifo_overflow <= dropEvt;
            if (accept || expired || state == IDLE) timeoutCnt <= '0;
            else                                    timeoutCnt <= timeoutCnt + TO_W'(1);
            if ((badFrame || expired || dropEvt) && (err_count != '1))
                err_count <= err_count + ERR_CNT_W'(1);
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (pushReq),
        .pop    (popFire),
        .wrData (pushEvt),
        .rdData (headEvt),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    assign keyBus.key_valid    = !fifoEmpty;
    assign keyBus.key_code     = headEvt.code;
    assign keyBus.key_extended = headEvt.extended;
    assign keyBus.key_release  = headEvt.released;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed self-checking bench for ps2_scan_decoder.
module tb_ps2_scan_decoder;

    localparam int unsigned TO = 40;

    logic       clk = 1'b0;
    logic       rstN;
    logic       frameReady;
    logic [7:0] scanCode;
    logic       parityBit;
    logic [1:0] commInitBits;
    logic       frameAck;
    logic       frameErr;
    logic       fifoOverflow;
    logic [7:0] errCount;

    int passCnt  = 0;
    int totalCnt = 0;
    int expErr   = 0;

    logic       rAck, rErr, rOvf, rVld, rExt, rRel, rAck2;
    logic [7:0] rCode;

    ps2_scan_decoder_if keyBus ();

    ps2_scan_decoder #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TO),
        .ERR_CNT_W      (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .frame_ready    (frameReady),
        .scan_code      (scanCode),
        .parity_bit     (parityBit),
        .comm_init_bits (commInitBits),
        .frame_ack      (frameAck),
        .keyBus         (keyBus),
        .frame_err      (frameErr),
        .fifo_overflow  (fifoOverflow),
        .err_count      (errCount)
    );

    always #5 clk = ~clk;

    function automatic logic oddPar(input logic [7:0] c);
        return ~^c;
    endfunction

    // Accept lands in the cycle after the first edge; results sampled one cycle later.
    task automatic sendFrame(input logic [7:0] code, input logic par, input logic [1:0] bits,
                             input logic rdyN, input logic rdyAfter);
        @(posedge clk); #1;
        scanCode = code; parityBit = par; commInitBits = bits;
        frameReady = 1'b1; keyBus.key_ready = rdyN;
        @(posedge clk); #1;
        rAck = frameAck; rErr = frameErr; rOvf = fifoOverflow; rVld = keyBus.key_valid;
        rCode = keyBus.key_code; rExt = keyBus.key_extended; rRel = keyBus.key_release;
        keyBus.key_ready = rdyAfter;
        @(posedge clk); #1;
        rAck2 = frameAck;
        frameReady = 1'b0;
    endtask

    task automatic checkEvent(input string name, input logic [7:0] code, input logic ext,
                              input logic rel);
        totalCnt++;
        if ({rVld, rCode, rExt, rRel} !== {1'b1, code, ext, rel})
            $display("FAIL %s: got v=%b code=%h ext=%b rel=%b, expected v=1 code=%h ext=%b rel=%b",
                     name, rVld, rCode, rExt, rRel, code, ext, rel);
        else passCnt++;
    endtask

    task automatic test_reset;
        rstN = 1'b0; frameReady = 1'b0; scanCode = '0; parityBit = 1'b0;
        commInitBits = 2'b01; keyBus.key_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        totalCnt++;
        if ({frameAck, frameErr, fifoOverflow, errCount, keyBus.key_valid, keyBus.key_code,
             keyBus.key_extended, keyBus.key_release} !== '0)
            $display("FAIL reset_outputs: got ack=%b err=%b ovf=%b cnt=%h vld=%b code=%h",
                     frameAck, frameErr, fifoOverflow, errCount, keyBus.key_valid, keyBus.key_code);
        else passCnt++;
        rstN = 1'b1;
    endtask

    task automatic test_plain;
        sendFrame(8'h1C, 1'b0, 2'b01, 1'b1, 1'b1);
        totalCnt++;
        if ({rAck, rAck2, rErr} !== 3'b100)
            $display("FAIL plain_ack: got ack=%b ack2=%b err=%b, expected 1 0 0", rAck, rAck2, rErr);
        else passCnt++;
        checkEvent("plain_event", 8'h1C, 1'b0, 1'b0);
        totalCnt++;
        if ({keyBus.key_valid, errCount} !== 9'd0)
            $display("FAIL plain_popped: got vld=%b cnt=%0d, expected 0 0", keyBus.key_valid, errCount);
        else passCnt++;
    endtask

    task automatic test_prefixes;
        sendFrame(8'hF0, 1'b1, 2'b01, 1'b1, 1'b1);
        totalCnt++;
        if (rVld !== 1'b0) $display("FAIL brk_prefix_no_event: got vld=%b, expected 0", rVld);
        else passCnt++;
        sendFrame(8'h1C, 1'b0, 2'b01, 1'b1, 1'b1);
        checkEvent("break_event", 8'h1C, 1'b0, 1'b1);
        totalCnt++;
        if (keyBus.key_valid !== 1'b0)
            $display("FAIL break_single: got vld=%b, expected 0", keyBus.key_valid);
        else passCnt++;
        sendFrame(8'hE0, 1'b0, 2'b01, 1'b1, 1'b1);
        sendFrame(8'hF0, 1'b1, 2'b01, 1'b1, 1'b1);
        totalCnt++;
        if (rVld !== 1'b0) $display("FAIL ext_brk_prefix_no_event: got vld=%b, expected 0", rVld);
        else passCnt++;
        sendFrame(8'h75, 1'b0, 2'b01, 1'b1, 1'b1);
        checkEvent("ext_break_event", 8'h75, 1'b1, 1'b1);
        sendFrame(8'hE1, 1'b1, 2'b01, 1'b1, 1'b1);
        checkEvent("e1_plain_event", 8'hE1, 1'b0, 1'b0);
    endtask

    task automatic test_errors;
        sendFrame(8'h1C, 1'b1, 2'b01, 1'b1, 1'b1);
        expErr = 1;
        totalCnt++;
        if ({rAck, rErr, rVld, errCount} !== {3'b110, 8'd1})
            $display("FAIL parity_err: got ack=%b err=%b vld=%b cnt=%0d, expected 1 1 0 1",
                     rAck, rErr, rVld, errCount);
        else passCnt++;
        sendFrame(8'h1C, 1'b0, 2'b00, 1'b1, 1'b1);
        expErr = 2;
        totalCnt++;
        if ({rErr, rVld, errCount} !== {2'b10, 8'd2})
            $display("FAIL stop_err: got err=%b vld=%b cnt=%0d, expected 1 0 2", rErr, rVld, errCount);
        else passCnt++;
        sendFrame(8'hE0, 1'b0, 2'b01, 1'b1, 1'b1);
        sendFrame(8'h1C, 1'b0, 2'b11, 1'b1, 1'b1);
        expErr = 3;
        totalCnt++;
        if ({rErr, rVld, errCount} !== {2'b10, 8'd3})
            $display("FAIL start_err: got err=%b vld=%b cnt=%0d, expected 1 0 3", rErr, rVld, errCount);
        else passCnt++;
        sendFrame(8'h1C, 1'b0, 2'b01, 1'b1, 1'b1);
        checkEvent("err_clears_prefix", 8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        int errAt;
        int errHits;
        errAt = -1; errHits = 0;
        sendFrame(8'hE0, 1'b0, 2'b01, 1'b1, 1'b1);
        for (int i = 1; i <= int'(TO) + 5; i++) begin
            @(posedge clk); #1;
            if (frameErr === 1'b1) begin
                errHits++;
                errAt = i;
            end
        end
        expErr = 4;
        totalCnt++;
        if (errHits != 1 || errAt != int'(TO) - 1 || errCount !== 8'(expErr))
            $display("FAIL timeout_err: got hits=%0d at=%0d cnt=%0d, expected 1 at %0d cnt %0d",
                     errHits, errAt, errCount, int'(TO) - 1, expErr);
        else passCnt++;
        sendFrame(8'h1C, 1'b0, 2'b01, 1'b1, 1'b1);
        checkEvent("after_timeout", 8'h1C, 1'b0, 1'b0);

        sendFrame(8'hE0, 1'b0, 2'b01, 1'b1, 1'b1);
        repeat (TO - 3) @(posedge clk);
        sendFrame(8'h1C, 1'b0, 2'b01, 1'b1, 1'b1);
        checkEvent("accept_at_expiry", 8'h1C, 1'b1, 1'b0);
        totalCnt++;
        if ({rErr, errCount} !== {1'b0, 8'(expErr)})
            $display("FAIL accept_wins: got err=%b cnt=%0d, expected 0 %0d", rErr, errCount, expErr);
        else passCnt++;
    endtask

    task automatic drainCheck(input string name, input logic [7:0] first);
        keyBus.key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            totalCnt++;
            if ({keyBus.key_valid, keyBus.key_code} !== {1'b1, first + 8'(i)})
                $display("FAIL %s_entry%0d: got vld=%b code=%h, expected 1 %h",
                         name, i, keyBus.key_valid, keyBus.key_code, first + 8'(i));
            else passCnt++;
            @(posedge clk); #1;
        end
        totalCnt++;
        if ({keyBus.key_valid, keyBus.key_code} !== 9'd0)
            $display("FAIL %s_empty: got vld=%b code=%h, expected 0 00",
                     name, keyBus.key_valid, keyBus.key_code);
        else passCnt++;
        keyBus.key_ready = 1'b0;
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 5; i++) begin
            sendFrame(8'h10 + 8'(i), oddPar(8'h10 + 8'(i)), 2'b01, 1'b0, 1'b0);
            if (i == 3 || i == 4) begin
                totalCnt++;
                if (rOvf !== (i == 4))
                    $display("FAIL overflow_pulse%0d: got ovf=%b, expected %b", i, rOvf, i == 4);
                else passCnt++;
            end
        end
        expErr = 5;
        totalCnt++;
        if (errCount !== 8'(expErr))
            $display("FAIL overflow_count: got cnt=%0d, expected %0d", errCount, expErr);
        else passCnt++;
        drainCheck("overflow", 8'h10);

        for (int i = 0; i < 4; i++)
            sendFrame(8'h20 + 8'(i), oddPar(8'h20 + 8'(i)), 2'b01, 1'b0, 1'b0);
        sendFrame(8'h24, oddPar(8'h24), 2'b01, 1'b1, 1'b0);
        totalCnt++;
        if ({rOvf, errCount} !== {1'b0, 8'(expErr)})
            $display("FAIL full_push_pop: got ovf=%b cnt=%0d, expected 0 %0d", rOvf, errCount, expErr);
        else passCnt++;
        drainCheck("push_pop", 8'h21);
    endtask

    task automatic test_reset_mid;
        sendFrame(8'hE0, 1'b0, 2'b01, 1'b1, 1'b1);
        rstN = 1'b0;
        #1;
        totalCnt++;
        if ({frameAck, frameErr, fifoOverflow, errCount, keyBus.key_valid} !== '0)
            $display("FAIL midreset_outputs: got ack=%b err=%b ovf=%b cnt=%0d vld=%b, expected 0",
                     frameAck, frameErr, fifoOverflow, errCount, keyBus.key_valid);
        else passCnt++;
        scanCode = 8'h1C; parityBit = 1'b0; commInitBits = 2'b01; frameReady = 1'b1;
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        rAck = frameAck; rErr = frameErr; rVld = keyBus.key_valid;
        rCode = keyBus.key_code; rExt = keyBus.key_extended; rRel = keyBus.key_release;
        totalCnt++;
        if ({rAck, rErr, errCount} !== {2'b10, 8'd0})
            $display("FAIL ready_high_at_release: got ack=%b err=%b cnt=%0d, expected 1 0 0",
                     rAck, rErr, errCount);
        else passCnt++;
        checkEvent("after_midreset", 8'h1C, 1'b0, 1'b0);
        @(posedge clk); #1;
        totalCnt++;
        if (frameAck !== 1'b0)
            $display("FAIL held_ready_no_reaccept: got ack=%b, expected 0", frameAck);
        else passCnt++;
        frameReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_plain();
        test_prefixes();
        test_errors();
        test_timeout();
        test_overflow();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Consumes the 11-bit frame fields produced by the PS/2 receive shift register: 8-bit scan code, parity bit, and start/stop bits.
- Checks framing and odd parity, folds E0 (extended) and F0 (break) prefixes into single key events, and buffers the events in a small FIFO.
- Presents the events on a valid/ready interface to the I2C paralellization logic.
- Runs in the fast-clock domain and drives the shift register's confirmSendData input through frame_ack.

Parameters:
- FIFO_DEPTH, 4: key-event FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 50000: clk cycles allowed between a prefix byte and the byte that completes it.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  fast system clock; this is the only clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_ready  in  1  level from the shift register; high when a complete frame is held.
- scan_code  in  8  received data byte, LSB = first bit on the wire.
- parity_bit  in  1  received parity bit.
- comm_init_bits  in  2  [1] = start bit, [0] = stop bit.
- frame_ack  out  1  one-cycle pulse when a frame is consumed; drives confirmSendData.
- key_valid  out  1  FIFO not empty.
- key_ready  in  1  downstream accepts the head entry.
- key_code  out  8  head entry: final scan code.
- key_extended  out  1  head entry: E0 prefix was seen.
- key_release  out  1  head entry: F0 prefix was seen.
- frame_err  out  1  one-cycle pulse on a parity, framing or timeout error.
- fifo_overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.
- err_count  out  ERR_CNT_W  saturating count of frame_err plus fifo_overflow events.

Behaviour:
- Reset: asynchronous on rst_n low.
  - All outputs are 0 and the FIFO is empty.
  - The FSM returns to IDLE and the timeout counter clears.
  - The frame_ready history register clears, so a frame_ready that is already high when reset releases counts as a new frame.
  - Reset during an in-progress prefix discards that prefix with no error.
- Frame accept: a registered copy of frame_ready is kept. A rising edge (current 1, previous 0) in cycle N is one accept.
  - frame_ack is high in cycle N+1 only. A frame_ready held high produces no further accepts.
- Validity: the frame is good when the start bit is 0, the stop bit is 1, and the XOR of scan_code and parity_bit is 1 (odd parity).
  - A bad frame pulses frame_err in N+1, increments err_count, forces the FSM to IDLE, pushes nothing, and still pulses frame_ack.
- FSM states and transitions for good frames:
  - IDLE: E0 -> EXT; F0 -> BRK; any other code pushes {code, ext=0, rel=0} and stays in IDLE.
  - EXT: F0 -> EXT_BRK; E0 stays in EXT; any other code pushes {code, 1, 0} and goes to IDLE.
  - BRK: E0 -> EXT_BRK; F0 stays in BRK; any other code pushes {code, 0, 1} and goes to IDLE.
  - EXT_BRK: E0 and F0 are ignored (stay); any other code pushes {code, 1, 1} and goes to IDLE.
  - E1 and all other codes are plain codes.
- Timeout:
  - The counter clears on every accept and counts in the non-IDLE states.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE, pulses frame_err and increments err_count.
  - If an accept coincides with expiry, the accept wins and there is no timeout error.
- FIFO:
  - Entry width is 10 bits.
  - A push takes effect at the end of cycle N, so key_valid/head data are visible in N+1 when the FIFO was empty.
  - A pop happens when key_valid and key_ready are both high.
  - Push while full with a simultaneous pop: both occur, with no overflow.
  - Push while full without a pop: the event is dropped, fifo_overflow pulses in N+1 and err_count increments.
  - Head outputs are 0 when the FIFO is empty.
  - Pointers wrap modulo FIFO_DEPTH, with one extra bit to distinguish full from empty.
- err_count saturates at all-ones. A frame_err and a fifo_overflow cannot occur in the same accept.

Decomposition:
- ps2_pkg holds:
  - constants PS2_CODE_EXT = 8'hE0 and PS2_CODE_BRK = 8'hF0;
  - the FSM state enum (IDLE, EXT, BRK, EXT_BRK);
  - the key-event struct {code[7:0], extended, release}.
- One sub-module: key_event_fifo, a synchronous FIFO with parameter DEPTH, a 10-bit payload, and push/pop/full/empty signals.

Test Plan:
- Frame 0x1C, parity 0, start 0, stop 1, with key_ready=1 -> frame_ack pulse, then key_valid with {0x1C, ext=0, rel=0}; err_count stays 0.
- Frames F0, 1C -> exactly one event {0x1C, 0, 1}; frames E0, F0, 75 -> {0x75, 1, 1}.
- Frame 0x1C with parity 1 -> frame_err pulse, err_count = 1, no event. Same with stop bit 0 -> err_count = 2.
- Frame E0, then TIMEOUT_CYCLES idle cycles, then 0x1C -> frame_err at timeout, then event {0x1C, 0, 0}.
- key_ready held 0 and five plain codes sent with FIFO_DEPTH=4 -> four events retained in order, one fifo_overflow pulse, err_count = 1. Fifth code sent in the same cycle as a pop -> no overflow.
- Assert rst_n low between E0 and the next code -> outputs zero; the next code 0x1C yields {0x1C, 0, 0}.
